// File: rtl/sobel_stream_edge.sv
// Streaming 3x3 Sobel edge detector: raster pixel stream in, one edge pixel out per input pixel.
// Two line buffers feed a 3x3 window; border outputs are forced to zero; optional binary threshold.

module sobel_stream_edge #(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256,
  parameter int unsigned PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  input  logic             mode,
  input  logic [PIX_W-1:0] threshold,
  output logic             busy
);

  localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned SUM_W = PIX_W + 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_in_cnt;
  logic [COL_W-1:0] r_in_col;
  logic [CNT_W-1:0] r_out_cnt;
  logic [COL_W-1:0] r_out_col;
  logic [ROW_W-1:0] r_out_row;
  logic             r_out_valid;
  logic             r_out_sof;
  logic             r_out_eof;
  logic [PIX_W-1:0] r_out_data;

  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  // Window columns c and c+1 relative to the pixel about to arrive (t=top, m=mid, b=bottom)
  logic [PIX_W-1:0] r_win_t1, r_win_t2;
  logic [PIX_W-1:0] r_win_m1, r_win_m2;
  logic [PIX_W-1:0] r_win_b1, r_win_b2;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_frame_start;
  logic             w_frame_px;
  logic [COL_W-1:0] w_wr_col;
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;
  logic [SUM_W-1:0] w_gx;
  logic [SUM_W-1:0] w_gy;
  logic [SUM_W-1:0] w_abs_x;
  logic [SUM_W-1:0] w_abs_y;
  logic [SUM_W-1:0] w_mag;
  logic [PIX_W-1:0] w_sat;
  logic [PIX_W-1:0] w_pix;
  logic             w_border;
  logic             w_load_run;
  logic             w_load_flush;
  logic             w_load;
  logic [PIX_W-1:0] w_load_data;

  function automatic logic [SUM_W-1:0] ext(input logic [PIX_W-1:0] v);
    return SUM_W'(v);
  endfunction

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_PRIME: in_ready = 1'b1;
      S_RUN:           in_ready = !r_out_valid || out_ready;
      default:         in_ready = 1'b0;
    endcase
  end

  assign w_in_fire     = in_valid && in_ready;
  assign w_out_fire    = r_out_valid && out_ready;
  assign w_frame_start = w_in_fire && (r_state == S_IDLE) && in_sof;
  assign w_frame_px    = w_in_fire && ((r_state != S_IDLE) || in_sof);
  assign w_wr_col      = w_frame_start ? '0 : r_in_col;

  // Frame-level sequencing: counts decide frame boundaries, not in_sof
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_start) w_state_nxt = S_PRIME;
      S_PRIME: if (w_in_fire && (r_in_cnt == CNT_W'(IMG_WIDTH))) w_state_nxt = S_RUN;
      S_RUN:   if (w_in_fire && (r_in_cnt == CNT_W'(NPIX - 1))) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_out_fire && r_out_eof) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_top = r_lb0[w_wr_col];
  assign w_mid = r_lb1[w_wr_col];

  // Sobel on the window formed once the incoming pixel becomes its bottom-right corner
  always_comb begin
    w_gx = (ext(w_top) + (ext(w_mid) << 1) + ext(in_data))
         - (ext(r_win_t1) + (ext(r_win_m1) << 1) + ext(r_win_b1));
    w_gy = (ext(r_win_b1) + (ext(r_win_b2) << 1) + ext(in_data))
         - (ext(r_win_t1) + (ext(r_win_t2) << 1) + ext(w_top));
    w_abs_x = w_gx[SUM_W-1] ? (SUM_W'(0) - w_gx) : w_gx;
    w_abs_y = w_gy[SUM_W-1] ? (SUM_W'(0) - w_gy) : w_gy;
    w_mag   = w_abs_x + w_abs_y;
    w_sat   = (|w_mag[SUM_W-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];
    if (mode) begin
      w_pix = (w_mag >= ext(threshold)) ? '1 : '0;
    end else begin
      w_pix = w_sat;
    end
  end

  assign w_border = (r_out_row == '0) || (r_out_row == ROW_W'(IMG_HEIGHT - 1)) ||
                    (r_out_col == '0) || (r_out_col == COL_W'(IMG_WIDTH - 1));

  assign w_load_run   = (r_state == S_RUN) && w_in_fire;
  assign w_load_flush = (r_state == S_FLUSH) && (!r_out_valid || out_ready) &&
                        (r_out_cnt != CNT_W'(NPIX));
  assign w_load       = w_load_run || w_load_flush;
  assign w_load_data  = (w_load_run && !w_border) ? w_pix : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_cnt    <= '0;
      r_in_col    <= '0;
      r_out_cnt   <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_frame_start) begin
        r_in_cnt <= CNT_W'(1);
        r_in_col <= COL_W'(1);
      end else if (w_frame_px) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
        r_in_col <= (r_in_col == COL_W'(IMG_WIDTH - 1)) ? '0 : r_in_col + COL_W'(1);
      end

      if (w_frame_start) begin
        r_out_cnt <= '0;
        r_out_col <= '0;
        r_out_row <= '0;
      end else if (w_load) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
        if (r_out_col == COL_W'(IMG_WIDTH - 1)) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : r_out_row + ROW_W'(1);
        end else begin
          r_out_col <= r_out_col + COL_W'(1);
        end
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_sof   <= (r_out_cnt == '0);
        r_out_eof   <= (r_out_cnt == CNT_W'(NPIX - 1));
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_sof   <= 1'b0;
        r_out_eof   <= 1'b0;
      end
    end
  end

  // Line buffers and window are refilled by PRIME each frame, so they carry no reset
  always_ff @(posedge clk) begin
    if (w_frame_px) begin
      r_lb0[w_wr_col] <= r_lb1[w_wr_col];
      r_lb1[w_wr_col] <= in_data;
      r_win_t1        <= r_win_t2;
      r_win_t2        <= w_top;
      r_win_m1        <= r_win_m2;
      r_win_m2        <= w_mid;
      r_win_b1        <= r_win_b2;
      r_win_b2        <= in_data;
    end
  end

endmodule

// File: tb/tb_sobel_stream_edge.sv
// Directed bench for sobel_stream_edge on 8x8 frames: flat, step and ramp images,
// threshold mode, random backpressure, pre-sof discard and mid-frame reset.

module tb_sobel_stream_edge;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       mode;
  logic [7:0] threshold;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  sobel_stream_edge #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .mode     (mode),
    .threshold(threshold),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scen 0: flat 0x80, scen 1: columns 0-3 = 0x00 / 4-7 = 0xFF, scen 2: ramp 10*col
  function automatic logic [7:0] in_pix(input int scen, input int j);
    int c;
    c = j % W;
    case (scen)
      0:       return 8'h80;
      1:       return (c < 4) ? 8'h00 : 8'hFF;
      default: return 8'(10 * c);
    endcase
  endfunction

  // Hand-derived |Gx|+|Gy| per scenario: flat 0, step 1020 at cols 3/4, ramp 80 everywhere inside
  function automatic logic [7:0] exp_pix(input int scen, input logic md, input logic [7:0] thr,
                                         input int j);
    int r;
    int c;
    int mag;
    r = j / W;
    c = j % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
    case (scen)
      0:       mag = 0;
      1:       mag = (c == 3 || c == 4) ? 1020 : 0;
      default: mag = 80;
    endcase
    if (md) return (mag >= int'(thr)) ? 8'hFF : 8'h00;
    return (mag > 255) ? 8'hFF : 8'(mag);
  endfunction

  task automatic run_frame(input int fid, input int scen, input logic md, input logic [7:0] thr,
                           input bit rnd, input int n_pre, input int stop_after);
    int in_idx;
    int out_idx;
    int cyc;
    int n_in;
    logic [7:0] e;
    in_idx    = 0;
    out_idx   = 0;
    cyc       = 0;
    n_in      = n_pre + NPIX;
    mode      = md;
    threshold = thr;
    while (out_idx < NPIX && cyc < 2000) begin
      @(negedge clk);
      in_valid = (in_idx < n_in);
      if (in_idx < n_pre) begin
        in_data = 8'hC3;
        in_sof  = 1'b0;
      end else begin
        in_data = in_pix(scen, in_idx - n_pre);
        in_sof  = (in_idx == n_pre);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && !out_ready)
        check($sformatf("f%0d backpressure in_ready", fid), 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        e = exp_pix(scen, md, thr, out_idx);
        check($sformatf("f%0d out%0d {data,sof,eof}", fid, out_idx),
              32'({out_data, out_sof, out_eof}),
              32'({e, 1'(out_idx == 0), 1'(out_idx == NPIX - 1)}));
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      cyc++;
      if (stop_after > 0 && in_idx >= n_pre + stop_after) break;
    end
    if (stop_after == 0) check($sformatf("f%0d output count", fid), 32'(out_idx), 32'(NPIX));
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    threshold = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset {valid,sof,eof,data,busy}",
          32'({out_valid, out_sof, out_eof, out_data, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle in_ready", 32'(in_ready), 32'd1);

    // flat image: all zeros, framing on first/last output
    run_frame(1, 0, 1'b0, 8'h00, 1'b0, 0, 0);
    check("f1 busy after frame", 32'(busy), 32'd0);

    // vertical step edge saturates at columns 3 and 4
    run_frame(2, 1, 1'b0, 8'h00, 1'b0, 0, 0);
    check("f2 busy after frame", 32'(busy), 32'd0);

    // horizontal ramp, magnitude mode
    run_frame(3, 2, 1'b0, 8'h00, 1'b0, 0, 0);

    // threshold just above and exactly at the interior magnitude
    run_frame(4, 2, 1'b1, 8'h51, 1'b0, 0, 0);
    run_frame(5, 2, 1'b1, 8'h50, 1'b0, 0, 0);

    // random backpressure must not change the stream
    run_frame(6, 2, 1'b0, 8'h00, 1'b1, 0, 0);
    check("f6 busy after frame", 32'(busy), 32'd0);

    // junk before sof, then reset 20 pixels into the frame
    run_frame(7, 2, 1'b0, 8'h00, 1'b0, 5, 20);
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset {valid,busy}", 32'({out_valid, busy}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-reset idle valid %0d", i), 32'(out_valid), 32'd0);
    end

    // clean frame after the reset
    run_frame(8, 1, 1'b0, 8'h00, 1'b0, 0, 0);
    check("f8 busy after frame", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
